// File: rtl/play_judge_pkg.sv
// Shared grade/state encodings and default timing and scoring constants for the rhythm judge.
// Pure declarations: no logic, no latency.
// No handshakes.
package play_judge_pkg;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'd0,
        GRADE_GOOD    = 2'd1,
        GRADE_PERFECT = 2'd2
    } grade_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_JUDGE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_LANES       = 7;
    localparam int DEF_TIME_W      = 32;
    localparam int DEF_WIN_PERFECT = 50;
    localparam int DEF_WIN_GOOD    = 150;
    localparam int DEF_PTS_PERFECT = 3;
    localparam int DEF_PTS_GOOD    = 1;
    localparam int DEF_SCORE_W     = 21;
    localparam int DEF_COMBO_W     = 12;
    localparam int DEF_COMBO_SHIFT = 3;

endpackage

// File: rtl/judge_window.sv
// Classifies a hit by time offset and lane into MISS/GOOD/PERFECT, flags early and late offsets.
// Combinational, zero latency.
// No handshakes.
module judge_window
    import play_judge_pkg::*;
#(
    parameter int TIME_W      = DEF_TIME_W,
    parameter int WIN_PERFECT = DEF_WIN_PERFECT,
    parameter int WIN_GOOD    = DEF_WIN_GOOD,
    parameter int LANE_W      = 3
) (
    input  logic signed [TIME_W:0] dt_i,
    input  logic [LANE_W-1:0]      hit_lane_i,
    input  logic [LANE_W-1:0]      goal_lane_i,
    output logic                   early_o,
    output logic                   late_o,
    output grade_e                 grade_o
);

    // One extra bit so the magnitude of the most negative dt cannot overflow.
    localparam int DW = TIME_W + 2;

    logic signed [DW-1:0] dt_x;
    logic signed [DW-1:0] abs_dt;
    logic signed [DW-1:0] win_p;
    logic signed [DW-1:0] win_g;

    always_comb begin
        dt_x    = {dt_i[TIME_W], dt_i};
        abs_dt  = dt_x[DW-1] ? -dt_x : dt_x;
        win_p   = DW'(WIN_PERFECT);
        win_g   = DW'(WIN_GOOD);
        early_o = (dt_x < -win_g);
        late_o  = (dt_x > win_g);
        grade_o = GRADE_MISS;
        if (hit_lane_i == goal_lane_i) begin
            if (abs_dt <= win_p) begin
                grade_o = GRADE_PERFECT;
            end else if (abs_dt <= win_g) begin
                grade_o = GRADE_GOOD;
            end
        end
    end

endmodule

// File: rtl/play_judge.sv
// Rhythm-game judge: fetches one note at a time, grades the player's hit, keeps score/combo stats.
// grade_valid strobes one cycle after the deciding hit or timeout cycle.
// goal_ready is high only while fetching; hits outside the wait window are dropped.
module play_judge
    import play_judge_pkg::*;
#(
    parameter int  LANES       = DEF_LANES,
    parameter int  TIME_W      = DEF_TIME_W,
    parameter int  WIN_PERFECT = DEF_WIN_PERFECT,
    parameter int  WIN_GOOD    = DEF_WIN_GOOD,
    parameter int  PTS_PERFECT = DEF_PTS_PERFECT,
    parameter int  PTS_GOOD    = DEF_PTS_GOOD,
    parameter int  SCORE_W     = DEF_SCORE_W,
    parameter int  COMBO_W     = DEF_COMBO_W,
    parameter int  COMBO_SHIFT = DEF_COMBO_SHIFT,
    localparam int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [TIME_W-1:0]  system_clock,
    input  logic               goal_valid,
    output logic               goal_ready,
    input  logic [LANE_W-1:0]  goal_lane,
    input  logic [TIME_W-1:0]  goal_time,
    input  logic               goal_last,
    input  logic               hit,
    input  logic [LANE_W-1:0]  hit_lane,
    output logic [LANES-1:0]   lane_led,
    output logic               grade_valid,
    output logic [1:0]         grade,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic               done
);

    localparam int SUM_W = ((SCORE_W > COMBO_W) ? SCORE_W : COMBO_W) + 2;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    state_e             state_q, state_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [TIME_W-1:0]  goal_time_q, goal_time_d;
    logic               last_q, last_d;
    grade_e             grade_q, grade_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [COMBO_W-1:0] max_q, max_d;

    logic signed [TIME_W:0] dt;
    logic                   win_early;
    logic                   win_late;
    grade_e                 win_grade;
    logic [SUM_W-1:0]       pts_w;
    logic [SUM_W-1:0]       sum_w;

    assign dt = $signed({1'b0, system_clock} - {1'b0, goal_time_q});

    judge_window #(
        .TIME_W      (TIME_W),
        .WIN_PERFECT (WIN_PERFECT),
        .WIN_GOOD    (WIN_GOOD),
        .LANE_W      (LANE_W)
    ) u_judge_window (
        .dt_i        (dt),
        .hit_lane_i  (hit_lane),
        .goal_lane_i (lane_q),
        .early_o     (win_early),
        .late_o      (win_late),
        .grade_o     (win_grade)
    );

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        goal_time_d = goal_time_q;
        last_d      = last_q;
        grade_d     = grade_q;
        score_d     = score_q;
        combo_d     = combo_q;
        max_d       = max_q;
        pts_w       = (grade_q == GRADE_PERFECT) ? SUM_W'(PTS_PERFECT) : SUM_W'(PTS_GOOD);
        sum_w       = SUM_W'(score_q) + pts_w + SUM_W'(combo_q >> COMBO_SHIFT);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (goal_valid) begin
                    lane_d      = goal_lane;
                    goal_time_d = goal_time;
                    last_d      = goal_last;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A hit outranks the timeout; a far-too-early hit is simply ignored.
                if (hit) begin
                    if (!win_early) begin
                        grade_d = win_grade;
                        state_d = ST_JUDGE;
                    end
                end else if (win_late) begin
                    grade_d = GRADE_MISS;
                    state_d = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                if (grade_q != GRADE_MISS) begin
                    combo_d = (combo_q == COMBO_MAX) ? combo_q : combo_q + COMBO_W'(1);
                    score_d = (sum_w > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum_w[SCORE_W-1:0];
                end else begin
                    combo_d = '0;
                end
                if (combo_d > max_q) begin
                    max_d = combo_d;
                end
                state_d = last_q ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!en) begin
            state_d = ST_IDLE;
            grade_d = GRADE_MISS;
            score_d = '0;
            combo_d = '0;
            max_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            goal_time_q <= '0;
            last_q      <= 1'b0;
            grade_q     <= GRADE_MISS;
            score_q     <= '0;
            combo_q     <= '0;
            max_q       <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            goal_time_q <= goal_time_d;
            last_q      <= last_d;
            grade_q     <= grade_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_q       <= max_d;
        end
    end

    assign goal_ready  = (state_q == ST_FETCH);
    assign grade_valid = (state_q == ST_JUDGE);
    assign done        = (state_q == ST_DONE);
    assign lane_led    = (state_q == ST_WAIT) ? (LANES'(1) << lane_q) : '0;
    assign grade       = grade_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign max_combo   = max_q;

endmodule

// File: tb/tb_play_judge.sv
// Directed bench for play_judge: table of single-note vectors plus hand-written multi-cycle sequences.
module tb_play_judge;

    localparam int LANES = 7;
    localparam int TW    = 32;
    localparam int LW    = 3;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [TW-1:0] system_clock;
    logic          goal_valid;
    logic          goal_ready;
    logic [LW-1:0] goal_lane;
    logic [TW-1:0] goal_time;
    logic          goal_last;
    logic          hit;
    logic [LW-1:0] hit_lane;
    logic [LANES-1:0] lane_led;
    logic          grade_valid;
    logic [1:0]    grade;
    logic [20:0]   score;
    logic [11:0]   combo;
    logic [11:0]   max_combo;
    logic          done;

    play_judge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .system_clock (system_clock),
        .goal_valid   (goal_valid),
        .goal_ready   (goal_ready),
        .goal_lane    (goal_lane),
        .goal_time    (goal_time),
        .goal_last    (goal_last),
        .hit          (hit),
        .hit_lane     (hit_lane),
        .lane_led     (lane_led),
        .grade_valid  (grade_valid),
        .grade        (grade),
        .score        (score),
        .combo        (combo),
        .max_combo    (max_combo),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int g_lane;
        int h_lane;
        int h_time;
        int exp_grade;
        int exp_score;
        int exp_combo;
        int exp_max;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int lane, input int t, input bit last);
        for (int i = 0; i < 10 && !goal_ready; i++) cyc();
        chk("goal_ready_in_fetch", {31'd0, goal_ready}, 32'd1);
        system_clock = 800;
        goal_valid   = 1'b1;
        goal_lane    = lane[LW-1:0];
        goal_time    = t;
        goal_last    = last;
        cyc();
        goal_valid   = 1'b0;
        goal_last    = 1'b0;
    endtask

    task automatic hit_at(input int lane, input int t);
        system_clock = t;
        hit          = 1'b1;
        hit_lane     = lane[LW-1:0];
        cyc();
        hit          = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] led_exp;

        // goal lane, hit lane, hit time, grade, score, combo, max_combo (goal time always 1000)
        tbl[0]  = '{2, 2, 1030, 2,  3, 1, 1};
        tbl[1]  = '{0, 0, 1050, 2,  6, 2, 2};
        tbl[2]  = '{1, 1, 1051, 1,  7, 3, 3};
        tbl[3]  = '{3, 3,  950, 2, 10, 4, 4};
        tbl[4]  = '{4, 4,  850, 1, 11, 5, 5};
        tbl[5]  = '{5, 5, 1150, 1, 12, 6, 6};
        tbl[6]  = '{6, 6, 1000, 2, 15, 7, 7};
        tbl[7]  = '{2, 2,  990, 2, 18, 8, 8};
        tbl[8]  = '{1, 1, 1010, 2, 22, 9, 9};
        tbl[9]  = '{2, 5, 1000, 0, 22, 0, 9};
        tbl[10] = '{0, 0, 1151, 0, 22, 0, 9};
        tbl[11] = '{3, 3, 1100, 1, 23, 1, 9};

        rst_n        = 1'b0;
        en           = 1'b0;
        system_clock = '0;
        goal_valid   = 1'b0;
        goal_lane    = '0;
        goal_time    = '0;
        goal_last    = 1'b0;
        hit          = 1'b0;
        hit_lane     = '0;
        #12;
        chk("rst_lane_led", {25'd0, lane_led}, 32'd0);
        chk("rst_grade_valid", {31'd0, grade_valid}, 32'd0);
        chk("rst_score", {11'd0, score}, 32'd0);
        chk("rst_goal_ready", {31'd0, goal_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        cyc();
        en = 1'b1;

        for (int v = 0; v < 12; v++) begin
            offer(tbl[v].g_lane, 1000, 1'b0);
            led_exp = 32'd1 << tbl[v].g_lane;
            chk("vec_lane_led", {25'd0, lane_led}, led_exp);
            chk("vec_no_early_grade", {31'd0, grade_valid}, 32'd0);
            hit_at(tbl[v].h_lane, tbl[v].h_time);
            chk("vec_grade_valid", {31'd0, grade_valid}, 32'd1);
            chk("vec_grade", {30'd0, grade}, tbl[v].exp_grade);
            cyc();
            chk("vec_strobe_one_cycle", {31'd0, grade_valid}, 32'd0);
            chk("vec_score", {11'd0, score}, tbl[v].exp_score);
            chk("vec_combo", {20'd0, combo}, tbl[v].exp_combo);
            chk("vec_max_combo", {20'd0, max_combo}, tbl[v].exp_max);
        end

        // Timeout: dt=150 still waits, dt=151 decides, strobe on the following cycle.
        offer(0, 1000, 1'b0);
        system_clock = 1150;
        cyc();
        chk("timeout_not_yet", {31'd0, grade_valid}, 32'd0);
        system_clock = 1151;
        cyc();
        system_clock = 1152;
        chk("timeout_strobe", {31'd0, grade_valid}, 32'd1);
        chk("timeout_grade", {30'd0, grade}, 32'd0);
        cyc();
        chk("timeout_combo", {20'd0, combo}, 32'd0);
        chk("timeout_max", {20'd0, max_combo}, 32'd9);
        chk("timeout_score", {11'd0, score}, 32'd23);

        // Far-early hit ignored, then a good hit yields exactly one GOOD.
        offer(4, 1000, 1'b0);
        hit_at(4, 800);
        chk("early_ignored", {31'd0, grade_valid}, 32'd0);
        chk("early_still_pending", {25'd0, lane_led}, 32'd16);
        hit_at(4, 900);
        chk("early_then_good_valid", {31'd0, grade_valid}, 32'd1);
        chk("early_then_good_grade", {30'd0, grade}, 32'd1);
        cyc();
        chk("early_then_good_score", {11'd0, score}, 32'd24);
        chk("early_then_good_combo", {20'd0, combo}, 32'd1);

        // A hit during FETCH must not be queued for the next note.
        hit_at(2, 1000);
        offer(2, 1000, 1'b0);
        cyc();
        chk("fetch_hit_dropped", {31'd0, grade_valid}, 32'd0);
        hit_at(2, 1000);
        cyc();
        chk("after_drop_score", {11'd0, score}, 32'd27);
        chk("after_drop_combo", {20'd0, combo}, 32'd2);

        en = 1'b0;
        cyc();
        chk("en_low_score", {11'd0, score}, 32'd0);
        chk("en_low_combo", {20'd0, combo}, 32'd0);
        chk("en_low_max", {20'd0, max_combo}, 32'd0);
        chk("en_low_ready", {31'd0, goal_ready}, 32'd0);
        en = 1'b1;

        // 16 PERFECTs from zero combo: 16*3 + sum(k>>3, k=0..15) = 48 + 8.
        for (int k = 0; k < 16; k++) begin
            offer(k % 7, 1000, 1'b0);
            hit_at(k % 7, 1000 + k);
            chk("run_grade", {30'd0, grade}, 32'd2);
            cyc();
        end
        chk("run_score", {11'd0, score}, 32'd56);
        chk("run_combo", {20'd0, combo}, 32'd16);
        chk("run_max", {20'd0, max_combo}, 32'd16);

        // Final note: bonus 16>>3 = 2 on top of 3 points.
        offer(1, 1000, 1'b1);
        hit_at(1, 1000);
        cyc();
        chk("last_done", {31'd0, done}, 32'd1);
        chk("last_ready", {31'd0, goal_ready}, 32'd0);
        chk("last_score", {11'd0, score}, 32'd61);
        cyc();
        cyc();
        chk("done_holds", {31'd0, done}, 32'd1);
        chk("done_ready_low", {31'd0, goal_ready}, 32'd0);
        en = 1'b0;
        cyc();
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("done_score_cleared", {11'd0, score}, 32'd0);
        en = 1'b1;

        // Asynchronous reset in the middle of WAIT.
        offer(2, 1000, 1'b0);
        hit_at(2, 1000);
        cyc();
        offer(3, 1000, 1'b0);
        chk("pre_rst_score", {11'd0, score}, 32'd3);
        chk("pre_rst_led", {25'd0, lane_led}, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lane_led", {25'd0, lane_led}, 32'd0);
        chk("arst_score", {11'd0, score}, 32'd0);
        chk("arst_combo", {20'd0, combo}, 32'd0);
        chk("arst_max", {20'd0, max_combo}, 32'd0);
        chk("arst_grade", {30'd0, grade}, 32'd0);
        chk("arst_grade_valid", {31'd0, grade_valid}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_ready", {31'd0, goal_ready}, 32'd0);
        #2;
        rst_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
